// File: rtl/cnn2d_window_feeder.sv
// cnn2d_window_feeder: producer side of a 3x3 convolution MAC.
// Loads a 3x3 signed 4-bit kernel serially, then streams a raster-order image
// of signed 8-bit pixels through two line buffers. It presents each complete
// 3x3 window as registered parallel outputs with a one-cycle win_valid strobe.
// Optional build macro CNN2D_STRIDE2_EN: emit only windows whose completing
// pixel has an even row and an even column (stride 2). Otherwise stride is 1.
module cnn2d_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_valid,
  input  logic signed [3:0] w_data,
  input  logic              pix_valid,
  input  logic signed [7:0] pix_data,
  output logic              pix_ready,
  output logic signed [7:0] X_00, X_01, X_02, X_10, X_11, X_12, X_20, X_21, X_22,
  output logic signed [3:0] W_00, W_01, W_02, W_10, W_11, W_12, W_20, W_21, W_22,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
`ifdef CNN2D_STRIDE2_EN
  // Last emitted window ends on the largest even row/column index.
  localparam logic [CW-1:0] COL_LAST_WIN = CW'(((IMG_W - 1) / 2) * 2);
  localparam logic [RW-1:0] ROW_LAST_WIN = RW'(((IMG_H - 1) / 2) * 2);
`else
  localparam logic [CW-1:0] COL_LAST_WIN = COL_END;
  localparam logic [RW-1:0] ROW_LAST_WIN = ROW_END;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      widx_q, widx_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            pix_ready_q;
  logic            win_valid_q;
  logic            frame_done_q;
  logic signed [3:0] w_q   [9];
  logic signed [7:0] win_q [3][3];
  logic signed [7:0] x_q   [3][3];
  logic signed [7:0] lb0_q [IMG_W];  // row r-2
  logic signed [7:0] lb1_q [IMG_W];  // row r-1

  logic              pix_acc_s;
  logic              win_s;
  logic              last_s;
  logic signed [7:0] new_col_s [3];

  // pix_ready is 1 only in STREAM, so acceptance needs no state term.
  assign pix_acc_s    = pix_valid && pix_ready_q;
  assign new_col_s[0] = lb0_q[col_q];
  assign new_col_s[1] = lb1_q[col_q];
  assign new_col_s[2] = pix_data;
`ifdef CNN2D_STRIDE2_EN
  assign win_s = (row_q >= ROW_TWO) && (col_q >= COL_TWO) && !row_q[0] && !col_q[0];
`else
  assign win_s = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`endif
  assign last_s = (row_q == ROW_LAST_WIN) && (col_q == COL_LAST_WIN);

  // Next-state logic: frame sequencing, weight index and raster position.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          widx_d  = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (w_valid) begin
          if (widx_q == 4'd8) begin
            state_d = STREAM;
            widx_d  = 4'd0;
            col_d   = {CW{1'b0}};
            row_d   = {RW{1'b0}};
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end else begin
          widx_d = widx_q;
        end
      end
      STREAM: begin
        if (pix_acc_s) begin
          if (col_q == COL_END) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_END) begin
              row_d   = {RW{1'b0}};
              state_d = IDLE;
            end else begin
              row_d = row_q + ROW_ONE;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers and output strobes; pix_ready follows the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      widx_q       <= 4'd0;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_ready_q  <= (state_d == STREAM);
      win_valid_q  <= pix_acc_s && win_s;
      frame_done_q <= pix_acc_s && win_s && last_s;
    end
  end

  // Kernel registers: one beat per w_valid cycle while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) w_q[i] <= 4'sd0;
    end else if ((state_q == LOAD_W) && w_valid) begin
      w_q[widx_q] <= w_data;
    end
  end

  // Line buffers: cascade the older row down and store the new pixel; no reset.
  always_ff @(posedge clk) begin
    if (pix_acc_s) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_data;
    end
  end

  // Shift window on every accept; publish it to X only when it is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= 8'sd0;
          x_q[i][j]   <= 8'sd0;
        end
      end
    end else if (pix_acc_s) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
        win_q[i][2] <= new_col_s[i];
        if (win_s) begin
          x_q[i][0] <= win_q[i][1];
          x_q[i][1] <= win_q[i][2];
          x_q[i][2] <= new_col_s[i];
        end
      end
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  assign X_00 = x_q[0][0];
  assign X_01 = x_q[0][1];
  assign X_02 = x_q[0][2];
  assign X_10 = x_q[1][0];
  assign X_11 = x_q[1][1];
  assign X_12 = x_q[1][2];
  assign X_20 = x_q[2][0];
  assign X_21 = x_q[2][1];
  assign X_22 = x_q[2][2];

  assign W_00 = w_q[0];
  assign W_01 = w_q[1];
  assign W_02 = w_q[2];
  assign W_10 = w_q[3];
  assign W_11 = w_q[4];
  assign W_12 = w_q[5];
  assign W_20 = w_q[6];
  assign W_21 = w_q[7];
  assign W_22 = w_q[8];

endmodule

// File: tb/tb_cnn2d_window_feeder.sv
// Directed self-checking bench for cnn2d_window_feeder.
// Default build: 4x4 image, stride 1. With CNN2D_STRIDE2_EN: 5x5 image, stride 2.
module tb_cnn2d_window_feeder;

`ifdef CNN2D_STRIDE2_EN
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int LR   = ((H - 1) / 2) * 2;
  localparam int LC   = ((W - 1) / 2) * 2;
  localparam int NWIN = ((H - 1) / 2) * ((W - 1) / 2);
`else
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int LR   = H - 1;
  localparam int LC   = W - 1;
  localparam int NWIN = (H - 2) * (W - 2);
`endif

  logic clk = 1'b0;
  logic rst_n, start, w_valid, pix_valid;
  logic signed [3:0] w_data;
  logic signed [7:0] pix_data;
  logic pix_ready, win_valid, frame_done;
  logic signed [7:0] X_00, X_01, X_02, X_10, X_11, X_12, X_20, X_21, X_22;
  logic signed [3:0] W_00, W_01, W_02, W_10, W_11, W_12, W_20, W_21, W_22;
  logic signed [7:0] xo [9];
  logic signed [3:0] wo [9];

  int n_chk  = 0;
  int n_fail = 0;
  int n_win  = 0;
  int kw [9] = '{1, -1, 2, -2, 3, -3, 4, -4, 7};

  always #5 clk = ~clk;

  cnn2d_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .w_valid(w_valid), .w_data(w_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .X_00(X_00), .X_01(X_01), .X_02(X_02), .X_10(X_10), .X_11(X_11),
    .X_12(X_12), .X_20(X_20), .X_21(X_21), .X_22(X_22),
    .W_00(W_00), .W_01(W_01), .W_02(W_02), .W_10(W_10), .W_11(W_11),
    .W_12(W_12), .W_20(W_20), .W_21(W_21), .W_22(W_22),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  assign xo = '{X_00, X_01, X_02, X_10, X_11, X_12, X_20, X_21, X_22};
  assign wo = '{W_00, W_01, W_02, W_10, W_11, W_12, W_20, W_21, W_22};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pval(input int mode, input int r, input int c);
    if (mode == 0) return W * r + c;
    return -1 - (W * r + c);
  endfunction

  function automatic bit exp_win(input int r, input int c);
`ifdef CNN2D_STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_X%0d", tag, k), xo[k], 0);
      check($sformatf("%s_W%0d", tag, k), wo[k], 0);
    end
  endtask

  // start together with a w_valid beat (that beat must be dropped), then 9 beats.
  task automatic load_weights();
    @(negedge clk);
    start = 1'b1; w_valid = 1'b1; w_data = 4'sd5;
    @(negedge clk);
    start = 1'b0;
    check("ld_start_ready", pix_ready, 0);
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1;
      w_data  = 4'(kw[i]);
      @(negedge clk);
      check($sformatf("ld_ready_beat%0d", i), pix_ready, (i == 8) ? 1 : 0);
    end
    w_valid = 1'b0;
    for (int k = 0; k < 9; k++) check($sformatf("ld_W%0d", k), wo[k], kw[k]);
  endtask

  // Send pixels in raster order; stop_after >= 0 aborts after that many pixels.
  task automatic run_frame(input int mode, input bit bubble, input bit poke,
                           input int stop_after);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (stop_after >= 0 && (r * W + c) >= stop_after) return;
        if (bubble) begin
          pix_valid = 1'b0;
          @(negedge clk);
          check("stall_win_valid", win_valid, 0);
        end
        pix_valid = 1'b1;
        pix_data  = 8'(pval(mode, r, c));
        if (poke && (r * W + c) == 5) begin
          start = 1'b1; w_valid = 1'b1; w_data = -4'sd8;
        end
        check($sformatf("pix_ready_r%0dc%0d", r, c), pix_ready, 1);
        @(negedge clk);
        pix_valid = 1'b0; start = 1'b0; w_valid = 1'b0;
        check($sformatf("win_valid_r%0dc%0d", r, c), win_valid, exp_win(r, c));
        check($sformatf("frame_done_r%0dc%0d", r, c), frame_done,
              (exp_win(r, c) && r == LR && c == LC) ? 1 : 0);
        if (exp_win(r, c)) begin
          n_win++;
          for (int k = 0; k < 9; k++)
            check($sformatf("X%0d%0d_r%0dc%0d", k / 3, k % 3, r, c), xo[k],
                  pval(mode, r - 2 + k / 3, c - 2 + k % 3));
        end
      end
    end
    check("end_pix_ready", pix_ready, 0);
    @(negedge clk);
    check("end_win_valid_drop", win_valid, 0);
    check("end_frame_done_drop", frame_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_valid = 1'b0; w_data = 4'sd0;
    pix_valid = 1'b0; pix_data = 8'sd0;
    #7;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: start and w_valid poked mid-stream must be ignored.
    load_weights();
    n_win = 0;
    run_frame(0, 1'b0, 1'b1, -1);
    check("f1_win_count", n_win, NWIN);
    for (int k = 0; k < 9; k++) check($sformatf("f1_W%0d_kept", k), wo[k], kw[k]);

    // Frame 2: pix_valid low every other cycle.
    load_weights();
    n_win = 0;
    run_frame(0, 1'b1, 1'b0, -1);
    check("f2_win_count", n_win, NWIN);

    // Abort after 6 pixels with reset, then a fresh negative-valued frame.
    load_weights();
    run_frame(1, 1'b0, 1'b0, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    load_weights();
    n_win = 0;
    run_frame(1, 1'b0, 1'b0, -1);
    check("f3_win_count", n_win, NWIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
